muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the M-extension operations in the single-cycle CPU core: MUL, MULH, MULHSU, MULHU, DIV and REM. It takes one request over a valid/ready handshake and iterates a shared 32-bit shift-add / restoring-subtract datapath. It returns the result over a second valid/ready handshake. Control stalls the pipeline on `Busy`, so the combinational ALU no longer has to close timing on a 32x32 multiply or divide.

## Interface
- `DATA_LENGTH`, 32: operand and result width.
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `ReqValid` in 1: a request is presented.
- `ReqReady` out 1: high only in IDLE.
- `AluOperation` in `ALUOP_WIDTH`: shared ALU op encoding from Constants.vh (`ALU_MUL`, `ALU_MULH`, `ALU_MULHSU`, `ALU_MULHU`, `ALU_DIV`, `ALU_REM`).
- `InputA` in `DATA_LENGTH`: multiplicand or dividend.
- `InputB` in `DATA_LENGTH`: multiplier or divisor.
- `Flush` in 1: abort the in-flight operation.
- `RespValid` out 1: `Result` is valid.
- `RespReady` in 1: the consumer accepts the result.
- `Result` out `DATA_LENGTH`: registered result.
- `Busy` out 1: high in CALC, FIX or DONE.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept:** a request is accepted when `ReqValid && ReqReady`. On accept, the block latches the operation, the operand signs and the operand magnitudes.
- **Signedness:**
  - MUL, MULH, DIV, REM: A signed, B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: A unsigned, B unsigned.
- **Multiply:** 32-bit unsigned shift-add on the magnitudes into a 64-bit accumulator, one bit per cycle.
- **Divide:** restoring division on the magnitudes, one quotient bit per cycle, with a 33-bit partial remainder.
- **Iteration counter:** 5 bits, cleared on accept. CALC exits to FIX when the counter is 31.
- **FIX (one cycle):**
  - Multiply: negate the 64-bit product if signA^signB. MUL takes bits [31:0]; the MULH variants take bits [63:32].
  - Divide: negate the quotient if signA^signB; negate the remainder if signA. DIV takes the quotient; REM takes the remainder.
- **Special cases** skip CALC and go IDLE→DONE:
  - Divide by zero: DIV = 0xFFFFFFFF; REM = InputA.
  - Overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
  - Any non-M operation: Result = 0.
- **DONE:** `RespValid`=1. `Result` is held stable until `RespReady`, then the block returns to IDLE.
- **Flush:** highest priority after reset. In any non-IDLE state it forces IDLE on the next edge, clears `RespValid`, and discards the result. `Flush` in IDLE has no effect and does not block an accept in the same cycle.
- **Reset:** an asynchronous reset mid-operation returns the block to IDLE immediately.
- **Reset values:**
  - `ReqReady`=1 (state IDLE).
  - `RespValid`=0.
  - `Busy`=0.
  - `Result`=0.
  - Counter and accumulators = 0.

## Timing
- Accept at edge t.
- **Iterative ops:** CALC covers t+1..t+32, FIX is at t+33, and `RespValid` is high from t+34.
- **Special cases:** `RespValid` is high from t+1.
- **One bubble minimum between operations:** the response handshake in DONE returns to IDLE. The next accept happens no earlier than the following cycle.
- **Output register:** `Result` and `RespValid` are registered. `ReqReady` and `Busy` decode the state with no combinational path from inputs.
- **Inputs ignored after accept:** `InputA`, `InputB` and `AluOperation` are don't-care after accept.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiply ops compute a single-cycle 32x32 signed/unsigned product in the accept cycle and go IDLE→FIX.
  - `RespValid` is high at t+2.
  - Divides are unchanged.
- `MULDIV_FAST_MUL_EN` undefined:
  - All multiplies use the 32-iteration shift-add path; `RespValid` is high at t+34.
  - No hardware multiplier is inferred.

## Test plan
- MUL, A=7, B=0xFFFFFFFD → `Result`=0xFFFFFFEB with `RespValid` at t+34 (t+2 with `MULDIV_FAST_MUL_EN`).
- A=B=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- A=0xFFFFFFF9, B=2:
  - DIV → 0xFFFFFFFD at t+34.
  - REM → 0xFFFFFFFF.
- Special cases, all at t+1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same → 0.
- Backpressure: hold `RespReady`=0 for 5 cycles after `RespValid`. Required: `Result` is stable, `ReqReady`=0 and `Busy`=1 throughout. After `RespReady`=1, the block is in IDLE next cycle and a new accept follows one cycle later.
- Flush at t+10 of a DIV → `RespValid` never asserts and `ReqReady`=1 at t+11. Repeat with `Reset` pulsed at t+10 → all outputs at reset values immediately, and a subsequent MUL completes correctly.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle sequencer for the M-extension operations (MUL, MULH, MULHSU,
// MULHU, DIV, REM). One request is taken over a valid/ready handshake. The
// operand magnitudes then iterate through a shared shift-add (multiply) or
// restoring-subtract (divide) datapath, one bit per cycle. The signed result
// is returned over a second valid/ready handshake.
//
// States: IDLE -> CALC (32 cycles) -> FIX (sign correction) -> DONE.
// Divide-by-zero, signed overflow and non-M operations go IDLE -> DONE.
//
// Ports
//   Clk           in   single clock, rising edge
//   Reset         in   asynchronous, active-high reset
//   ReqValid      in   request presented
//   ReqReady      out  high only in IDLE
//   AluOperation  in   shared ALU op encoding (ALU_* parameters below)
//   InputA        in   multiplicand / dividend
//   InputB        in   multiplier / divisor
//   Flush         in   abort the in-flight operation (ignored in IDLE)
//   RespValid     out  Result is valid (registered)
//   RespReady     in   consumer accepts the result
//   Result        out  registered result
//   Busy          out  high in CALC, FIX or DONE
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, multiplies form the full product in the accept cycle and
//   go straight to FIX. Divides are unchanged. When undefined, no hardware
//   multiplier is inferred.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int DATA_LENGTH = 32,
  parameter int ALUOP_WIDTH = 4,
  // These encodings must match the core's shared ALU op constants.
  parameter logic [ALUOP_WIDTH-1:0] ALU_MUL    = ALUOP_WIDTH'(9),
  parameter logic [ALUOP_WIDTH-1:0] ALU_MULH   = ALUOP_WIDTH'(10),
  parameter logic [ALUOP_WIDTH-1:0] ALU_MULHSU = ALUOP_WIDTH'(11),
  parameter logic [ALUOP_WIDTH-1:0] ALU_MULHU  = ALUOP_WIDTH'(12),
  parameter logic [ALUOP_WIDTH-1:0] ALU_DIV    = ALUOP_WIDTH'(13),
  parameter logic [ALUOP_WIDTH-1:0] ALU_REM    = ALUOP_WIDTH'(14)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic [ALUOP_WIDTH-1:0] AluOperation,
  input  logic [DATA_LENGTH-1:0] InputA,
  input  logic [DATA_LENGTH-1:0] InputB,
  input  logic                   Flush,
  output logic                   RespValid,
  input  logic                   RespReady,
  output logic [DATA_LENGTH-1:0] Result,
  output logic                   Busy
);

  localparam int W  = DATA_LENGTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ALUOP_WIDTH-1:0] op_q, op_d;
  logic                   sign_a_q, sign_a_d;
  logic                   sign_b_q, sign_b_d;
  logic [W-1:0]           mag_a_q, mag_a_d;
  logic [W-1:0]           mag_b_q, mag_b_d;
  // Multiply: {high, low} product accumulator, low half starts as multiplier.
  // Divide: low half holds the dividend shifting out / quotient shifting in.
  logic [2*W-1:0]         acc_q, acc_d;
  logic [W:0]             rem_q, rem_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic                   resp_valid_q, resp_valid_d;

  // ---------------------------------------------------------------------
  // Request decode (only meaningful in the accept cycle)
  // ---------------------------------------------------------------------
  logic         accept;
  logic         in_is_mul, in_is_div, in_sign_a, in_sign_b, in_special;
  logic [W-1:0] in_mag_a, in_mag_b, in_special_result;

  always_comb begin
    accept    = ReqValid && (state_q == S_IDLE);
    in_is_mul = (AluOperation == ALU_MUL)    || (AluOperation == ALU_MULH) ||
                (AluOperation == ALU_MULHSU) || (AluOperation == ALU_MULHU);
    in_is_div = (AluOperation == ALU_DIV)    || (AluOperation == ALU_REM);
    // A is unsigned only for MULHU; B is unsigned for MULHSU and MULHU.
    in_sign_a = InputA[W-1] && (AluOperation != ALU_MULHU);
    in_sign_b = InputB[W-1] && (AluOperation != ALU_MULHU) &&
                (AluOperation != ALU_MULHSU);
    in_mag_a  = in_sign_a ? -InputA : InputA;
    in_mag_b  = in_sign_b ? -InputB : InputB;

    in_special        = 1'b0;
    in_special_result = '0;
    if (!in_is_mul && !in_is_div) begin
      in_special = 1'b1;
    end else if (in_is_div && (InputB == '0)) begin
      in_special        = 1'b1;
      in_special_result = (AluOperation == ALU_DIV) ? '1 : InputA;
    end else if (in_is_div && (InputA == MIN_NEG) && (InputB == '1)) begin
      in_special        = 1'b1;
      in_special_result = (AluOperation == ALU_DIV) ? MIN_NEG : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Iteration and sign-fix datapath
  // ---------------------------------------------------------------------
  logic         q_is_mul;
  logic [W-1:0] mul_addend;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] mul_step;
  logic [W+1:0] div_shift, div_diff;
  logic         div_borrow;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0] quo_fix, rem_fix, fix_result;

  always_comb begin
    q_is_mul = (op_q == ALU_MUL)    || (op_q == ALU_MULH) ||
               (op_q == ALU_MULHSU) || (op_q == ALU_MULHU);

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole thing right.
    mul_addend = acc_q[0] ? mag_a_q : '0;
    mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};
    mul_step   = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: bring in the next dividend bit, trial-subtract the
    // divisor, keep the difference only when it did not borrow.
    div_shift  = {rem_q, acc_q[W-1]};
    div_diff   = div_shift - {2'b00, mag_b_q};
    div_borrow = div_diff[W+1];

    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = sign_a_q ? -rem_q[W-1:0] : rem_q[W-1:0];

    if (q_is_mul) begin
      fix_result = (op_q == ALU_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end else begin
      fix_result = (op_q == ALU_DIV) ? quo_fix : rem_fix;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_special) begin
            state_d = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (in_is_mul) begin
            state_d = S_FIX;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (RespReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush aborts anything in flight; in IDLE it must not block an accept.
    if (Flush && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------
  // FSM: state-decoded outputs (no input-to-output combinational path)
  // ---------------------------------------------------------------------
  always_comb begin
    ReqReady = (state_q == S_IDLE);
    Busy     = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = AluOperation;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          mag_a_d  = in_mag_a;
          mag_b_d  = in_mag_b;
          cnt_d    = '0;
          rem_d    = '0;
          acc_d    = {{W{1'b0}}, (in_is_mul ? in_mag_b : in_mag_a)};
`ifdef MULDIV_FAST_MUL_EN
          if (in_is_mul) begin
            acc_d = {{W{1'b0}}, in_mag_a} * {{W{1'b0}}, in_mag_b};
          end
`endif
          if (in_special) result_d = in_special_result;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (q_is_mul) begin
          acc_d = mul_step;
        end else begin
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_borrow};
          rem_d = div_borrow ? div_shift[W:0] : div_diff[W:0];
        end
      end
      S_FIX:   result_d = fix_result;
      default: ;
    endcase
  end

  // RespValid is registered straight from the next-state decode.
  always_comb begin
    resp_valid_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q         <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      mag_a_q      <= '0;
      mag_b_q      <= '0;
      acc_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      op_q         <= op_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      mag_a_q      <= mag_a_d;
      mag_b_q      <= mag_b_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign Result    = result_q;
  assign RespValid = resp_valid_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed, table-driven bench for muldiv_sequencer. Each table record holds
// an operation, operands, the hand-computed result and the response latency
// (edges after the accept edge until RespValid is seen). Hand-written
// sequences cover backpressure, Flush and asynchronous Reset mid-operation.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_MUL    = 4'd9;
  localparam logic [3:0] OP_MULH   = 4'd10;
  localparam logic [3:0] OP_MULHSU = 4'd11;
  localparam logic [3:0] OP_MULHU  = 4'd12;
  localparam logic [3:0] OP_DIV    = 4'd13;
  localparam logic [3:0] OP_REM    = 4'd14;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  alu_op;
  logic [31:0] in_a, in_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .Clk          (clk),
    .Reset        (rst),
    .ReqValid     (req_valid),
    .ReqReady     (req_ready),
    .AluOperation (alu_op),
    .InputA       (in_a),
    .InputB       (in_b),
    .Flush        (flush),
    .RespValid    (resp_valid),
    .RespReady    (resp_ready),
    .Result       (result),
    .Busy         (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, got);
    end
  endtask

  // Present a request at a negedge once ReqReady is seen; returns after the
  // accept edge with the request inputs scrambled (don't-care after accept).
  task automatic do_accept(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (ok) begin
      req_valid = 1'b1;
      alu_op    = op;
      in_a      = a;
      in_b      = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      alu_op    = 4'($urandom);
      in_a      = $urandom;
      in_b      = $urandom;
    end
  endtask

  // Count edges from the accept edge until RespValid is seen, then complete
  // the response handshake. lat = -1 on timeout.
  task automatic wait_resp(output int lat, output logic [31:0] res);
    lat = -1;
    res = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        res = result;
        break;
      end
    end
    if (lat > 0) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    logic        ok;
    int          lat;
    logic [31:0] res;
    logic        seen;

    vecs.push_back('{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
    vecs.push_back('{OP_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, MUL_LAT});
    vecs.push_back('{OP_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, MUL_LAT});
    vecs.push_back('{OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, MUL_LAT});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{OP_DIV,    32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, DIV_LAT});
    vecs.push_back('{OP_REM,    32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT});
    vecs.push_back('{OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPC_LAT});
    vecs.push_back('{OP_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPC_LAT});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT});
    vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT});
    vecs.push_back('{OP_ADD,    32'h0000_0003, 32'h0000_0004, 32'h0000_0000, SPC_LAT});

    rst        = 1'b1;
    req_valid  = 1'b0;
    alu_op     = '0;
    in_a       = '0;
    in_b       = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;

    // Reset values
    #12;
    check("reset_req_ready",  32'(req_ready),  32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_busy",       32'(busy),       32'd0);
    check("reset_result",     result,          32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_accept(vecs[i].op, vecs[i].a, vecs[i].b, ok);
      check($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
      wait_resp(lat, res);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: hold RespReady low for 5 cycles in DONE
    do_accept(OP_DIV, 32'd100, 32'd7, ok);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    check("bp_latency", 32'(lat), 32'(DIV_LAT));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_result_c%0d", k),     result,           32'd14);
      check($sformatf("bp_resp_valid_c%0d", k), 32'(resp_valid),  32'd1);
      check($sformatf("bp_req_ready_c%0d", k),  32'(req_ready),   32'd0);
      check($sformatf("bp_busy_c%0d", k),       32'(busy),        32'd1);
    end
    // Release, with a new request already waiting: it must not be taken in DONE.
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    alu_op     = OP_MUL;
    in_a       = 32'd3;
    in_b       = 32'd5;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp_idle_req_ready",  32'(req_ready),  32'd1);
    check("bp_idle_resp_valid", 32'(resp_valid), 32'd0);
    check("bp_idle_busy",       32'(busy),       32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_next_accept_busy", 32'(busy), 32'd1);
    wait_resp(lat, res);
    check("bp_next_result",  res,       32'd15);
    check("bp_next_latency", 32'(lat),  32'(MUL_LAT));

    // Flush at t+10 of a DIV
    do_accept(OP_DIV, 32'hFFFF_FFF9, 32'd2, ok);
    for (int k = 1; k < 10; k++) @(negedge clk);
    @(negedge clk);
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_req_ready",  32'(req_ready),  32'd1);
    check("flush_busy",       32'(busy),       32'd0);
    check("flush_resp_valid", 32'(resp_valid), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("flush_no_resp", 32'(seen), 32'd0);

    // Flush in IDLE does not block an accept in the same cycle
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    alu_op    = OP_DIV;
    in_a      = 32'd100;
    in_b      = 32'd7;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("idle_flush_accept_busy", 32'(busy), 32'd1);
    wait_resp(lat, res);
    check("idle_flush_result",  res,      32'd14);
    check("idle_flush_latency", 32'(lat), 32'(DIV_LAT));

    // Asynchronous reset mid-DIV: outputs return to reset values immediately
    do_accept(OP_DIV, 32'hFFFF_FFF9, 32'd2, ok);
    for (int k = 1; k < 10; k++) @(negedge clk);
    check("rst_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result",     result,          32'd0);
    #1;
    rst = 1'b0;
    do_accept(OP_MUL, 32'd7, 32'hFFFF_FFFD, ok);
    check("post_rst_accept", 32'(ok), 32'd1);
    wait_resp(lat, res);
    check("post_rst_mul_result",  res,      32'hFFFF_FFEB);
    check("post_rst_mul_latency", 32'(lat), 32'(MUL_LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
